// File: rtl/halflife_ctrl_if.sv
// Command, timer-drive and status bundle for the half-life sequencing controller.
// The controller connects through the slave modport; the requester uses master.
interface halflife_ctrl_if #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned VAL_W      = 4
);
    logic                  start;
    logic                  abort;
    logic [VAL_W-1:0]      init_val;
    logic [PRESCALE_W-1:0] period;
    logic [3:0]            max_halv;
    logic                  dir;

    logic                  load;
    logic [VAL_W-1:0]      in;
    logic                  up;
    logic                  down;
    logic [VAL_W-1:0]      value;
    logic [3:0]            halvings;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, init_val, period, max_halv, dir,
        input  load, in, up, down, value, halvings, busy, done
    );

    modport slave (
        input  start, abort, init_val, period, max_halv, dir,
        output load, in, up, down, value, halvings, busy, done
    );
endinterface

// File: rtl/halflife_ctrl.sv
// Half-life sequencer: loads an initial quantity, then halves it once per period,
// strobing the timer with a reload and a direction pulse on every step.
module halflife_ctrl #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned VAL_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    halflife_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] per_q, per_d;
    logic                  dir_q, dir_d;
    logic [3:0]            maxh_q, maxh_d;

    logic                  load_q, load_d;
    logic [VAL_W-1:0]      in_q, in_d;
    logic                  up_q, up_d;
    logic                  down_q, down_d;
    logic [VAL_W-1:0]      value_q, value_d;
    logic [3:0]            halv_q, halv_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  term;

    // In RUN, load_q marks a step cycle; the value/halvings it shows decide termination.
    assign term = (value_q == '0) || ((maxh_q != 4'd0) && (halv_q == maxh_q));

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        per_d   = per_q;
        dir_d   = dir_q;
        maxh_d  = maxh_q;
        load_d  = 1'b0;
        in_d    = '0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        value_d = value_q;
        halv_d  = halv_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    per_d   = (bus.period == '0) ? PRESCALE_W'(1) : bus.period;
                    dir_d   = bus.dir;
                    maxh_d  = bus.max_halv;
                    state_d = StLoad;
                    load_d  = 1'b1;
                    in_d    = bus.init_val;
                    value_d = bus.init_val;
                    halv_d  = 4'd0;
                    busy_d  = 1'b1;
                    pre_d   = '0;
                end
            end
            StLoad: begin
                pre_d = '0;
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (value_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (load_q && term) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (pre_q == per_q - PRESCALE_W'(1)) begin
                        value_d = value_q >> 1;
                        halv_d  = (halv_q == 4'hf) ? halv_q : halv_q + 4'd1;
                        load_d  = 1'b1;
                        in_d    = value_q >> 1;
                        up_d    = ~dir_q;
                        down_d  = dir_q;
                        pre_d   = '0;
                    end else begin
                        pre_d = pre_q + PRESCALE_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pre_q   <= '0;
            per_q   <= '0;
            dir_q   <= 1'b0;
            maxh_q  <= 4'd0;
            load_q  <= 1'b0;
            in_q    <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            value_q <= '0;
            halv_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            maxh_q  <= maxh_d;
            load_q  <= load_d;
            in_q    <= in_d;
            up_q    <= up_d;
            down_q  <= down_d;
            value_q <= value_d;
            halv_q  <= halv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.load     = load_q;
    assign bus.in       = in_q;
    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.value    = value_q;
    assign bus.halvings = halv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: doc/halflife_ctrl.md
Name: halflife_ctrl

Overview:
Sequencing controller for the half-life timer datapath. It accepts a start command with an initial quantity and a step period, issues the initial load, then halves the quantity once per period. Each halving drives the timer with a reload of the halved value plus a direction strobe. It reports progress (`value`, `halvings`), signals completion with a one-cycle done pulse, and sits between the top-level I/O wrapper and the timer core.

Parameters:
PRESCALE_W, 16, width of the period input and the internal prescaler counter.
VAL_W, 4, width of the quantity bus driven to the timer (`in`) and of `value`/`init_val`.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a sequence; sampled only in IDLE.
abort  input  1  cancel the sequence in progress; highest priority after rst.
init_val  input  VAL_W  initial quantity; latched on accepted start.
period  input  PRESCALE_W  cycles per half-life step; latched on accepted start; 0 is treated as 1.
max_halv  input  4  stop after this many halvings; 0 means stop only when value reaches 0.
dir  input  1  step strobe select, latched on start: 0 drives `up`, 1 drives `down`.
load  output  1  one-cycle reload strobe to the timer.
in  output  VAL_W  reload data; valid while load=1, otherwise 0.
up  output  1  one-cycle step strobe (dir=0).
down  output  1  one-cycle step strobe (dir=1).
value  output  VAL_W  current shadow quantity.
halvings  output  4  halvings completed in this sequence.
busy  output  1  high in LOAD and RUN.
done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. On rst, every output is 0, the FSM goes to IDLE, and the prescaler, latched period and latched dir clear.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 latches init_val, period (0→1), dir and max_halv.
  - Next state is LOAD. start in any other state is ignored.
- LOAD (exactly one cycle):
  - load=1, in=init_val, value=init_val, halvings=0, busy=1, prescaler=0.
  - If init_val==0, next state is DONE. Otherwise next state is RUN.
- RUN:
  - The prescaler increments each cycle starting from 0.
  - When prescaler==P-1, the next cycle is a step cycle. In the step cycle:
    - value ← value>>1 and halvings ← halvings+1.
    - load=1 with in equal to the new value.
    - up=1 if dir=0, or down=1 if dir=1.
    - prescaler ← 0.
  - Strobes are therefore spaced exactly P cycles apart. The first strobe falls P+1 cycles after the load cycle.
- Termination: the FSM enters DONE in the cycle after a step where the new value==0, or where max_halv≠0 and the new halvings==max_halv.
- DONE (exactly one cycle):
  - done=1, busy=0. value and halvings hold their final values. Next state is IDLE.
- value and halvings hold in IDLE until the next accepted start.
- halvings saturates at 15. With VAL_W=4 this is never reached naturally, because value hits 0 after at most 4 halvings.
- abort in LOAD or RUN:
  - Next cycle is IDLE with load/up/down/busy=0 and no done pulse.
  - value and halvings hold their last values.
  - If the abort cycle is itself a step cycle, that step's strobes still appear (they are already registered), and no further strobes follow.
- abort in IDLE or DONE has no effect; done is still pulsed if the FSM is in DONE.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.
- rst mid-operation: immediate return to the reset state on the next edge. No done pulse.
- Period changes after start have no effect until the next start.
- Outputs load, up and down are never high outside LOAD or step cycles. up and down are never high together.

Test Plan:
- Basic decay:
  - Stimulus: rst released; init_val=12, period=3, dir=1, max_halv=0; start at cycle 0.
  - Response: load/in=12 at cycle 1; step strobes (down=1, load=1) at cycles 5, 8, 11, 14 with in=6, 3, 1, 0; halvings=4; done=1 at cycle 15; busy high cycles 1–14.
- Halving limit and up strobes:
  - Stimulus: init_val=15, period=1, dir=0, max_halv=2.
  - Response: up strobes at cycles 3 and 4 with in=7, 3; done at cycle 5; final value=3, halvings=2; down never asserted.
- Degenerate inputs:
  - Stimulus: init_val=0 with any period.
  - Response: load at cycle 1, done at cycle 2, no up/down strobes.
  - Stimulus: period=0.
  - Response: identical to period=1.
- Abort:
  - Stimulus: init_val=12, period=4; abort at cycle 8.
  - Response: step at cycle 6 (in=6); no strobe after cycle 8; busy=0 from cycle 9; done never asserted; value=6, halvings=1.
- Start while busy and sync reset:
  - Stimulus: start pulses during RUN.
  - Response: ignored; sequence timing unchanged.
  - Stimulus: rst=1 mid-RUN.
  - Response: all outputs 0 on the next cycle; a fresh start afterwards behaves exactly as in the basic decay test.
